// File: rtl/register_write_arbiter.sv
// Round-robin arbiter granting R requesters one write each into a shared
// load-enabled register; a two-state FSM spaces writes at least two cycles apart.
module register_write_arbiter #(
    parameter  int N  = 8,
    parameter  int R  = 4,
    parameter  int CW = 16,
    localparam int PW = (R > 1) ? $clog2(R) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] req_data,
    input  logic           lock,
    output logic [R-1:0]   grant,
    output logic           load_signal,
    output logic [N-1:0]   data_input,
    output logic           busy,
    output logic [PW-1:0]  last_grantee,
    output logic [CW-1:0]  write_count
);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [R-1:0]    grant_d;
    logic            load_d;
    logic            busy_d;
    logic [N-1:0]    data_d;
    logic [PW-1:0]   last_d;
    logic [CW-1:0]   count_d;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW:0]     cand_sum;
    logic [PW-1:0]   cand;
    logic [N-1:0]    sel_data;

    // Search starts at ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < R; k++) begin
            cand_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand_sum >= (PW+1)'(R))
                cand_sum = cand_sum - (PW+1)'(R);
            cand = cand_sum[PW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < R; i++)
            if (win == PW'(i))
                sel_data = req_data[i*N +: N];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = '0;
        load_d  = 1'b0;
        busy_d  = 1'b0;
        data_d  = data_input;
        last_d  = last_grantee;
        count_d = write_count;
        case (state_q)
            IDLE: begin
                if (!lock && found) begin
                    state_d      = LOAD;
                    grant_d[win] = 1'b1;
                    load_d       = 1'b1;
                    busy_d       = 1'b1;
                    data_d       = sel_data;
                    last_d       = win;
                    ptr_d        = (win == PW'(R-1)) ? '0 : win + PW'(1);
                    count_d      = write_count + CW'(1);
                end
            end
            LOAD: begin
                // Strobes drop; data_input keeps the value just written.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant        <= '0;
            load_signal  <= 1'b0;
            busy         <= 1'b0;
            data_input   <= '0;
            last_grantee <= '0;
            write_count  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant        <= grant_d;
            load_signal  <= load_d;
            busy         <= busy_d;
            data_input   <= data_d;
            last_grantee <= last_d;
            write_count  <= count_d;
        end
    end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter: default instance plus a CW=4
// instance for write-counter wrap; an external register model follows load_signal.
module tb_register_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        lock;
    logic [3:0]  grant;
    logic        load_signal;
    logic [7:0]  data_input;
    logic        busy;
    logic [1:0]  last_grantee;
    logic [15:0] write_count;

    logic [3:0]  req2;
    logic [31:0] req_data2;
    logic        lock2;
    logic [3:0]  grant2;
    logic        load2;
    logic [7:0]  data2;
    logic        busy2;
    logic [1:0]  last2;
    logic [3:0]  count2;

    logic [7:0]  reg_q;
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    register_write_arbiter #(.N(8), .R(4), .CW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .lock(lock),
        .grant(grant), .load_signal(load_signal), .data_input(data_input),
        .busy(busy), .last_grantee(last_grantee), .write_count(write_count)
    );

    register_write_arbiter #(.N(8), .R(4), .CW(4)) dut_cw4 (
        .clk(clk), .reset(reset), .req(req2), .req_data(req_data2), .lock(lock2),
        .grant(grant2), .load_signal(load2), .data_input(data2),
        .busy(busy2), .last_grantee(last2), .write_count(count2)
    );

    // The shared register being written
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            reg_q <= '0;
        else if (load_signal) reg_q <= data_input;
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '0; lock = 1'b0; req2 = '0; lock2 = 1'b0;
        req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        req_data2 = {8'h00, 8'h00, 8'h00, 8'h5A};
        repeat (2) @(negedge clk);
        checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (load_signal !== 1'b0) begin fails++; $display("FAIL reset_load got=%b exp=0", load_signal); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (data_input !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", data_input); end
        checks++; if (last_grantee !== 2'd0) begin fails++; $display("FAIL reset_last got=%0d exp=0", last_grantee); end
        checks++; if (write_count !== 16'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", write_count); end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        req = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin fails++; $display("FAIL single_grant got=%b exp=0100", grant); end
        checks++; if (load_signal !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL single_load got=%b/%b exp=1/1", load_signal, busy); end
        checks++; if (data_input !== 8'hA5) begin fails++; $display("FAIL single_data got=%h exp=a5", data_input); end
        checks++; if (last_grantee !== 2'd2) begin fails++; $display("FAIL single_last got=%0d exp=2", last_grantee); end
        checks++; if (write_count !== 16'd1) begin fails++; $display("FAIL single_count got=%0d exp=1", write_count); end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (grant !== 4'b0000 || load_signal !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_pulse got=%b/%b/%b exp=0000/0/0", grant, load_signal, busy); end
        checks++; if (data_input !== 8'hA5) begin fails++; $display("FAIL single_hold got=%h exp=a5", data_input); end
        checks++; if (reg_q !== 8'hA5) begin fails++; $display("FAIL single_reg got=%h exp=a5", reg_q); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (grant !== exp_g[i]) begin fails++; $display("FAIL rr_grant%0d got=%b exp=%b", i, grant, exp_g[i]); end
            @(negedge clk);
            checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL rr_gap%0d got=%b exp=0000", i, grant); end
        end
        checks++; if (write_count !== 16'd5) begin fails++; $display("FAIL rr_count got=%0d exp=5", write_count); end
        req = 4'b0000;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_g [3];
        exp_g = '{4'b0001, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        checks++; if (grant !== 4'b1000) begin fails++; $display("FAIL wrap_pre got=%b exp=1000", grant); end
        req = 4'b1001;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (grant !== exp_g[i]) begin fails++; $display("FAIL wrap_grant%0d got=%b exp=%b", i, grant, exp_g[i]); end
            @(negedge clk);
        end
        req = 4'b0000;
    endtask

    task automatic test_lock();
        logic [7:0] reg_before;
        reg_before = reg_q;
        lock = 1'b1;
        req  = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (grant !== 4'b0000 || load_signal !== 1'b0) begin fails++; $display("FAIL lock_hold%0d got=%b/%b exp=0000/0", i, grant, load_signal); end
        end
        checks++; if (reg_q !== reg_before) begin fails++; $display("FAIL lock_reg got=%h exp=%h", reg_q, reg_before); end
        lock = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 4'b0010) begin fails++; $display("FAIL lock_release got=%b exp=0010", grant); end
        lock = 1'b1;
        req  = 4'b0000;
        @(negedge clk);
        checks++; if (reg_q !== 8'h22) begin fails++; $display("FAIL lock_in_load_reg got=%h exp=22", reg_q); end
        checks++; if (write_count !== 16'd5) begin fails++; $display("FAIL lock_count got=%0d exp=5", write_count); end
        lock = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        req = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin fails++; $display("FAIL midrst_pre got=%b exp=0100", grant); end
        req = 4'b0000;
        #2 reset = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000 || load_signal !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_strobes got=%b/%b/%b exp=0000/0/0", grant, load_signal, busy); end
        checks++; if (data_input !== 8'h00) begin fails++; $display("FAIL midrst_data got=%h exp=00", data_input); end
        checks++; if (write_count !== 16'd0) begin fails++; $display("FAIL midrst_count got=%0d exp=0", write_count); end
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b1111;
        @(negedge clk);
        checks++; if (grant !== 4'b0001 || last_grantee !== 2'd0) begin fails++; $display("FAIL midrst_ptr got=%b/%0d exp=0001/0", grant, last_grantee); end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_count_wrap();
        req2 = 4'b0001;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            checks++; if (count2 !== 4'(i)) begin fails++; $display("FAIL cw4_count%0d got=%0d exp=%0d", i, count2, i % 16); end
            checks++; if (grant2 !== 4'b0001 || busy2 !== 1'b1 || load2 !== 1'b1) begin fails++; $display("FAIL cw4_grant%0d got=%b/%b/%b exp=0001/1/1", i, grant2, busy2, load2); end
            @(negedge clk);
        end
        checks++; if (data2 !== 8'h5A || last2 !== 2'd0) begin fails++; $display("FAIL cw4_data got=%h/%0d exp=5a/0", data2, last2); end
        req2 = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_wrap();
        test_lock();
        test_reset_mid_load();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
